// File: rtl/spike_pkg.sv
// Shared constants and elaboration-time helpers for the spike popcount
// pipeline: tree geometry (level sizes and flat node offsets) and widths.
package spike_pkg;

  localparam int SPIKE_W_DEF = 32;
  localparam int ACC_W_DEF   = 16;
  localparam int BEAT_W_DEF  = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int cnt_w(input int w);
    return clog2(w + 1);
  endfunction

  function automatic int stages(input int w);
    return clog2(w);
  endfunction

  // Number of nodes at tree level l (level 0 = the raw spike bits).
  function automatic int lvl_n(input int w, input int l);
    return (w + (1 << l) - 1) >> l;
  endfunction

  // Registered levels 1..STAGES are packed into one flat node array.
  function automatic int lvl_off(input int w, input int l);
    int off;
    off = 0;
    for (int k = 1; k < l; k++) off += lvl_n(w, k);
    return off;
  endfunction

endpackage

// File: rtl/spike_popcount_tree.sv
// Registered popcount adder tree: one level per clock, odd nodes pass through,
// valid/last travel alongside; every register advances only on ce_i.
module spike_popcount_tree
  import spike_pkg::*;
#(
  parameter  int SPIKE_W = SPIKE_W_DEF,
  localparam int CNT_W   = cnt_w(SPIKE_W)
) (
  input  logic               s_clk,
  input  logic               s_rst,
  input  logic               ce_i,
  input  logic [SPIKE_W-1:0] data_i,
  input  logic               valid_i,
  input  logic               last_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               valid_o,
  output logic               last_o
);

  localparam int STAGES = stages(SPIKE_W);
  localparam int TOTAL  = lvl_off(SPIKE_W, STAGES + 1);

  logic [CNT_W-1:0]  node_q [TOTAL];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] lst_q;

  genvar l, i;
  for (l = 1; l <= STAGES; l++) begin : g_lvl
    localparam int N   = lvl_n(SPIKE_W, l);
    localparam int NP  = lvl_n(SPIKE_W, l - 1);
    localparam int OFF = lvl_off(SPIKE_W, l);
    for (i = 0; i < N; i++) begin : g_node
      logic [CNT_W-1:0] a_d;
      logic [CNT_W-1:0] b_d;
      if (l == 1) begin : g_leaf
        assign a_d = CNT_W'(data_i[2*i]);
        if (2*i + 1 < NP) begin : g_pair
          assign b_d = CNT_W'(data_i[2*i+1]);
        end else begin : g_pass
          assign b_d = '0;
        end
      end else begin : g_inner
        localparam int OFFP = lvl_off(SPIKE_W, l - 1);
        assign a_d = node_q[OFFP + 2*i];
        if (2*i + 1 < NP) begin : g_pair
          assign b_d = node_q[OFFP + 2*i + 1];
        end else begin : g_pass
          assign b_d = '0;
        end
      end

      always_ff @(posedge s_clk) begin
        if (s_rst) begin
          node_q[OFF + i] <= '0;
        end else if (ce_i) begin
          node_q[OFF + i] <= a_d + b_d;
        end
      end
    end
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      vld_q <= '0;
      lst_q <= '0;
    end else if (ce_i) begin
      vld_q[0] <= valid_i;
      lst_q[0] <= valid_i & last_i;
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
        lst_q[s] <= lst_q[s-1];
      end
    end
  end

  assign cnt_o   = node_q[TOTAL-1];
  assign valid_o = vld_q[STAGES-1];
  assign last_o  = lst_q[STAGES-1];

endmodule

// File: rtl/spike_popcount_accum.sv
// Pipelined spike popcount with per-frame accumulation and a valid/ready
// frame-result port. Define SPIKE_ACC_SAT_EN for a saturating accumulator.
module spike_popcount_accum
  import spike_pkg::*;
#(
  parameter  int SPIKE_W = SPIKE_W_DEF,
  parameter  int ACC_W   = ACC_W_DEF,
  parameter  int BEAT_W  = BEAT_W_DEF,
  localparam int CNT_W   = cnt_w(SPIKE_W)
) (
  input  logic               s_clk,
  input  logic               s_rst,
  input  logic [SPIKE_W-1:0] i_Spikesdata,
  input  logic               i_Spikesdata_valid,
  input  logic               i_Spikesdata_last,
  output logic               o_Spikesdata_ready,
  output logic [CNT_W-1:0]   o_SpikeSum,
  output logic               o_SpikeSum_valid,
  output logic [ACC_W-1:0]   o_AccSum,
  output logic [BEAT_W-1:0]  o_AccBeats,
  output logic               o_AccSum_valid,
  input  logic               i_AccSum_ready,
  output logic               o_AccOvf
);

  logic             ce;
  logic [CNT_W-1:0] t_cnt;
  logic             t_vld;
  logic             t_lst;

  logic              first_q;
  logic [ACC_W-1:0]  acc_q, acc_d, base;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic [ACC_W-1:0]  sum_out_q;
  logic [BEAT_W-1:0] beats_out_q;
  logic              res_vld_q;

  // A pending result that downstream refuses freezes the whole pipeline.
  assign ce                 = ~(res_vld_q & ~i_AccSum_ready);
  assign o_Spikesdata_ready = ce;

  spike_popcount_tree #(.SPIKE_W(SPIKE_W)) u_tree (
    .s_clk   (s_clk),
    .s_rst   (s_rst),
    .ce_i    (ce),
    .data_i  (i_Spikesdata),
    .valid_i (i_Spikesdata_valid),
    .last_i  (i_Spikesdata_last),
    .cnt_o   (t_cnt),
    .valid_o (t_vld),
    .last_o  (t_lst)
  );

`ifdef SPIKE_ACC_SAT_EN
  logic [ACC_W:0] sum_w;
  logic           ovf_q, ovf_d, ovf_out_q;

  always_comb begin
    base    = first_q ? '0 : acc_q;
    beats_d = first_q ? BEAT_W'(1) : beats_q + 1'b1;
    sum_w   = {1'b0, base} + (ACC_W+1)'(t_cnt);
    ovf_d   = (~first_q & ovf_q) | sum_w[ACC_W];
    acc_d   = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      ovf_q     <= 1'b0;
      ovf_out_q <= 1'b0;
    end else if (ce && t_vld) begin
      ovf_q <= ovf_d;
      if (t_lst) ovf_out_q <= ovf_d;
    end
  end

  assign o_AccOvf = ovf_out_q;
`else
  always_comb begin
    base    = first_q ? '0 : acc_q;
    beats_d = first_q ? BEAT_W'(1) : beats_q + 1'b1;
    acc_d   = base + ACC_W'(t_cnt);
  end

  assign o_AccOvf = 1'b0;
`endif

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      first_q     <= 1'b1;
      acc_q       <= '0;
      beats_q     <= '0;
      sum_out_q   <= '0;
      beats_out_q <= '0;
      res_vld_q   <= 1'b0;
    end else begin
      if (ce && t_vld) begin
        first_q <= t_lst;
        acc_q   <= acc_d;
        beats_q <= beats_d;
      end
      // A fresh frame result overwrites; otherwise a handshake retires it.
      if (ce && t_vld && t_lst) begin
        sum_out_q   <= acc_d;
        beats_out_q <= beats_d;
        res_vld_q   <= 1'b1;
      end else if (i_AccSum_ready) begin
        res_vld_q <= 1'b0;
      end
    end
  end

  assign o_SpikeSum       = t_cnt;
  assign o_SpikeSum_valid = t_vld;
  assign o_AccSum         = sum_out_q;
  assign o_AccBeats       = beats_out_q;
  assign o_AccSum_valid   = res_vld_q;

endmodule

// File: tb/tb_spike_popcount_accum.sv
// Randomized and directed bench for spike_popcount_accum against a queue-based
// frame model; a second instance with a 6-bit accumulator covers overflow.
module tb_spike_popcount_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic        valid;
  logic        last;
  logic        acc_ready = 1'b1;
  logic        rdy_force;
  logic        rdy_rand_en;

  logic        ready;
  logic [5:0]  spk_sum;
  logic        spk_vld;
  logic [15:0] acc_sum;
  logic [7:0]  acc_beats;
  logic        acc_vld;
  logic        acc_ovf;

  logic        ready6;
  logic [5:0]  spk_sum6;
  logic        spk_vld6;
  logic [5:0]  acc_sum6;
  logic [7:0]  acc_beats6;
  logic        acc_vld6;
  logic        acc_ovf6;

  int n_tests = 0;
  int n_fail  = 0;

  int beat_q[$];
  int fr_sum_q[$], fr_beats_q[$], fr_ovf_q[$];
  int fr6_sum_q[$], fr6_ovf_q[$];
  int run_tot = 0;
  int run_beats = 0;

  spike_popcount_accum dut (
    .s_clk(clk), .s_rst(rst),
    .i_Spikesdata(data), .i_Spikesdata_valid(valid), .i_Spikesdata_last(last),
    .o_Spikesdata_ready(ready),
    .o_SpikeSum(spk_sum), .o_SpikeSum_valid(spk_vld),
    .o_AccSum(acc_sum), .o_AccBeats(acc_beats), .o_AccSum_valid(acc_vld),
    .i_AccSum_ready(acc_ready), .o_AccOvf(acc_ovf)
  );

  spike_popcount_accum #(.ACC_W(6)) dut6 (
    .s_clk(clk), .s_rst(rst),
    .i_Spikesdata(data), .i_Spikesdata_valid(valid), .i_Spikesdata_last(last),
    .o_Spikesdata_ready(ready6),
    .o_SpikeSum(spk_sum6), .o_SpikeSum_valid(spk_vld6),
    .o_AccSum(acc_sum6), .o_AccBeats(acc_beats6), .o_AccSum_valid(acc_vld6),
    .i_AccSum_ready(acc_ready), .o_AccOvf(acc_ovf6)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_acc(input int tot, input int w);
`ifdef SPIKE_ACC_SAT_EN
    return (tot > (1 << w) - 1) ? (1 << w) - 1 : tot;
`else
    return tot % (1 << w);
`endif
  endfunction

  function automatic int exp_ovf(input int tot, input int w);
`ifdef SPIKE_ACC_SAT_EN
    return (tot > (1 << w) - 1) ? 1 : 0;
`else
    return (tot < 0 || w < 0) ? 1 : 0;
`endif
  endfunction

  // Downstream ready: random or forced, applied 2 time units after each edge.
  always @(posedge clk) begin
    #2;
    acc_ready = rdy_rand_en ? (($urandom % 4) != 0) : rdy_force;
  end

  // Scoreboard: check what is visible now, then record any beat accepted now.
  always @(negedge clk) begin
    if (rst) begin
      beat_q.delete(); fr_sum_q.delete(); fr_beats_q.delete(); fr_ovf_q.delete();
      fr6_sum_q.delete(); fr6_ovf_q.delete();
      run_tot = 0; run_beats = 0;
    end else begin
      check("ready_rule", 32'(ready), 32'(!(acc_vld && !acc_ready)));
      check("ready6", 32'(ready6), 32'(ready));
      if (spk_vld) begin
        if (beat_q.size() == 0) check("spk_spurious", 32'(spk_vld), 0);
        else begin
          check("spk_sum", 32'(spk_sum), beat_q[0]);
          if (ready) void'(beat_q.pop_front());
        end
      end
      if (acc_vld) begin
        if (fr_sum_q.size() == 0) check("acc_spurious", 32'(acc_vld), 0);
        else begin
          check("acc_sum", 32'(acc_sum), fr_sum_q[0]);
          check("acc_beats", 32'(acc_beats), fr_beats_q[0]);
          check("acc_ovf", 32'(acc_ovf), fr_ovf_q[0]);
          if (acc_ready) begin
            void'(fr_sum_q.pop_front()); void'(fr_beats_q.pop_front()); void'(fr_ovf_q.pop_front());
          end
        end
      end
      if (acc_vld6) begin
        if (fr6_sum_q.size() == 0) check("acc6_spurious", 32'(acc_vld6), 0);
        else begin
          check("acc6_sum", 32'(acc_sum6), fr6_sum_q[0]);
          check("acc6_ovf", 32'(acc_ovf6), fr6_ovf_q[0]);
          if (acc_ready) begin
            void'(fr6_sum_q.pop_front()); void'(fr6_ovf_q.pop_front());
          end
        end
      end
      if (valid && ready) begin
        beat_q.push_back($countones(data));
        run_tot += $countones(data);
        run_beats++;
        if (last) begin
          fr_sum_q.push_back(exp_acc(run_tot, 16));
          fr_beats_q.push_back(run_beats % 256);
          fr_ovf_q.push_back(exp_ovf(run_tot, 16));
          fr6_sum_q.push_back(exp_acc(run_tot, 6));
          fr6_ovf_q.push_back(exp_ovf(run_tot, 6));
          run_tot = 0; run_beats = 0;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepts.
  task automatic send_beat(input logic [31:0] w, input logic l);
    data = w; valid = 1'b1; last = l;
    @(negedge clk);
    for (int k = 0; k < 60 && !ready; k++) @(negedge clk);
    if (!ready) check("send_timeout", 32'(ready), 1);
    @(posedge clk); #1;
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  // Watches ncyc cycles: first SpikeSum sighting, first/last rise of AccSum_valid.
  task automatic watch(input int ncyc, output int spk_lat, output int spk_val,
                       output int lat_first, output int lat_last,
                       output int sum_last, output int beats_last, output int n_rise);
    logic prev;
    prev = acc_vld;
    spk_lat = 0; spk_val = -1; lat_first = 0; lat_last = 0;
    sum_last = -1; beats_last = -1; n_rise = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (spk_vld && spk_lat == 0) begin spk_lat = k; spk_val = int'(spk_sum); end
      if (acc_vld && !prev) begin
        if (n_rise == 0) lat_first = k;
        lat_last = k; sum_last = int'(acc_sum); beats_last = int'(acc_beats);
        n_rise++;
      end
      prev = acc_vld;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] words [4];
    int          pcs   [4];
    int sl, sv, lf, ll, sm, bt, nr, tot_b;
    logic [31:0] w;

    words[0] = 32'h007C7C7C; words[1] = 32'h00FFFFFF; words[2] = 32'h73; words[3] = 32'h0F;
    pcs[0] = 15; pcs[1] = 24; pcs[2] = 5; pcs[3] = 4;
    rdy_rand_en = 1'b0; rdy_force = 1'b1;
    rst = 1'b1; data = '0; valid = 1'b0; last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_spk", 32'(spk_sum), 0);   check("rst_spk_vld", 32'(spk_vld), 0);
    check("rst_acc", 32'(acc_sum), 0);   check("rst_beats", 32'(acc_beats), 0);
    check("rst_acc_vld", 32'(acc_vld), 0); check("rst_ovf", 32'(acc_ovf), 0);
    check("rst_ready", 32'(ready), 1);
    @(posedge clk); #1;

    // Single-beat frames: value and latency.
    for (int b = 0; b < 4; b++) begin
      send_beat(words[b], 1'b1);
      watch(8, sl, sv, lf, ll, sm, bt, nr);
      check("single_spk_lat", sl, 5); check("single_spk_val", sv, pcs[b]);
      check("single_acc_lat", lf, 6); check("single_acc", sm, pcs[b]);
      check("single_beats", bt, 1);
    end

    // Four-beat frame, then two frames back to back.
    for (int b = 0; b < 4; b++) send_beat(words[b], b == 3);
    watch(8, sl, sv, lf, ll, sm, bt, nr);
    check("frame_lat", lf, 6); check("frame_sum", sm, 48); check("frame_beats", bt, 4);
    for (int r = 0; r < 2; r++)
      for (int b = 0; b < 4; b++) send_beat(words[b], b == 3);
    watch(10, sl, sv, lf, ll, sm, bt, nr);
    check("b2b_rises", nr, 2); check("b2b_lat", ll, 6);
    check("b2b_sum", sm, 48); check("b2b_beats", bt, 4);

    // All ones and all zeros, then a three-beat overflow frame.
    send_beat(32'hFFFFFFFF, 1'b1);
    watch(8, sl, sv, lf, ll, sm, bt, nr);
    check("ones_spk", sv, 32); check("ones_acc", sm, 32); check("ones_beats", bt, 1);
    send_beat(32'h0, 1'b1);
    watch(8, sl, sv, lf, ll, sm, bt, nr);
    check("zero_acc", sm, 0); check("zero_beats", bt, 1);
    for (int b = 0; b < 3; b++) send_beat(32'hFFFFFFFF, b == 2);
    watch(8, sl, sv, lf, ll, sm, bt, nr);
    check("ff3_acc", sm, 96); check("ff3_beats", bt, 3);
`ifdef SPIKE_ACC_SAT_EN
    check("ff3_acc6", 32'(acc_sum6), 63); check("ff3_ovf6", 32'(acc_ovf6), 1);
`else
    check("ff3_acc6", 32'(acc_sum6), 32); check("ff3_ovf6", 32'(acc_ovf6), 0);
`endif

    // Stall: result held for 3 cycles while the next frame keeps arriving.
    rdy_force = 1'b0;
    idle();
    for (int b = 0; b < 4; b++) send_beat(words[b], b == 3);
    tot_b = 0;
    fork
      begin
        for (int b = 0; b < 6; b++) begin
          w = $urandom;
          tot_b += $countones(w);
          send_beat(w, b == 5);
        end
      end
      begin
        for (int k = 0; k < 40 && !acc_vld; k++) @(negedge clk);
        check("stall_seen", 32'(acc_vld), 1);
        for (int k = 0; k < 3; k++) begin
          if (k > 0) @(negedge clk);
          check("stall_ready", 32'(ready), 0);
          check("stall_hold", 32'(acc_sum), 48);
          check("stall_hold_vld", 32'(acc_vld), 1);
        end
        @(posedge clk); #1;
        rdy_force = 1'b1;
      end
    join
    watch(12, sl, sv, lf, ll, sm, bt, nr);
    check("post_stall_sum", sm, tot_b); check("post_stall_beats", bt, 6);

    // Reset mid-frame discards the partial frame.
    send_beat(32'hFFFFFFFF, 1'b0);
    send_beat(32'hFFFFFFFF, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mrst_spk", 32'(spk_sum), 0);   check("mrst_spk_vld", 32'(spk_vld), 0);
    check("mrst_acc", 32'(acc_sum), 0);   check("mrst_beats", 32'(acc_beats), 0);
    check("mrst_acc_vld", 32'(acc_vld), 0); check("mrst_ready", 32'(ready), 1);
    @(posedge clk); #1;
    send_beat(32'h0F, 1'b1);
    watch(8, sl, sv, lf, ll, sm, bt, nr);
    check("mrst_next_acc", sm, 4); check("mrst_next_beats", bt, 1);

    // Random traffic with random downstream backpressure.
    rdy_rand_en = 1'b1;
    for (int it = 0; it < 3000; it++) begin
      if (($urandom % 10) < 7) begin
        case ($urandom % 4)
          0: w = 32'hFFFFFFFF;
          1: w = $urandom & $urandom;
          2: w = ($urandom % 8 == 0) ? 32'h0 : $urandom;
          default: w = $urandom;
        endcase
        send_beat(w, ($urandom % 5) == 0);
      end else if (($urandom % 400) == 0) begin
        rst = 1'b1;
        idle();
        rst = 1'b0;
      end else begin
        idle();
      end
    end
    rdy_rand_en = 1'b0; rdy_force = 1'b1;
    repeat (20) idle();
    check("drain_beats", beat_q.size(), 0);
    check("drain_frames", fr_sum_q.size(), 0);
    check("drain_frames6", fr6_sum_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
